ioctl_upload_responder: RTL and testbench
=========================================

// Module: ioctl_upload_responder
// PURPOSE
// - HPS->core read-back path: answers ioctl_rd requests during an ioctl upload by fetching bytes from a core-side RAM.
// - The RAM holds high-score/NVRAM data.
// - Counterpart of the ioctl download write path. Sits in emu between hps_io and the game RAM's second port.
// PARAMETERS
// - UPLOAD_INDEX  8'd4   ioctl_index value this block serves; other indexes are ignored.
// - SIZE          256    bytes in the upload window (addr 0..SIZE-1). Legal range 1..65535.
// - AW            16     width of mem_addr.
// - RD_LAT        1      mem_q valid RD_LAT cycles after a granted mem_rd (1..4).
// - FILL          8'hFF  byte returned for out-of-window addresses.
// PORTS
// - clk_sys        in   1   system clock
// - reset_n        in   1   asynchronous active-low reset
// - ioctl_upload   in   1   upload session active (from hps_io)
// - ioctl_index    in   8   session index
// - ioctl_rd       in   1   1-cycle read strobe for ioctl_addr
// - ioctl_addr     in   25  requested byte address
// - ioctl_din      out  8   returned byte; valid while ioctl_wait=0 after rd
// - ioctl_wait     out  1   stall hps_io until ioctl_din is valid
// - mem_rd         out  1   read request to game RAM port
// - mem_addr       out  AW  RAM byte address
// - mem_gnt        in   1   RAM port granted this cycle (shared with game CPU)
// - mem_q          in   8   RAM read data
// - busy           out  1   FSM not IDLE; game side may defer writes
// BEHAVIOUR
// - Reset: ioctl_din=8'h00, ioctl_wait=0, mem_rd=0, mem_addr=0, busy=0, FSM=IDLE.
// - Active session: act = ioctl_upload & (ioctl_index==UPLOAD_INDEX). ioctl_rd while !act is ignored.
// - FSM states: IDLE, REQ, LAT, DONE.
// - IDLE: on ioctl_rd & act, latch the address.
//   - If ioctl_addr < SIZE: go to REQ. ioctl_wait=1 on the next edge; mem_rd=1; mem_addr=ioctl_addr[AW-1:0].
//   - If out of window: ioctl_din<=FILL; wait stays 0; stay in IDLE. Latency is 1 cycle.
// - REQ: hold mem_rd/mem_addr until mem_gnt=1. Then drop mem_rd, load the latency counter with RD_LAT-1, go to LAT.
//   - No timeout; wait stays 1 for as long as the grant is withheld.
// - LAT: count down to 0. Then ioctl_din<=mem_q, go to DONE.
// - DONE: ioctl_wait<=0, go to IDLE.
// - Minimum latency (rd to wait falling) is RD_LAT+2 cycles.
// - ioctl_rd arriving while not IDLE is a protocol violation. Ignore it; do not queue it.
// - Session abort: act falls in any state -> next cycle IDLE, wait=0, mem_rd=0, ioctl_din unchanged.
// - Reset mid-fetch: all outputs return to reset values asynchronously. An in-flight mem_q is discarded.
// - Window compare: ioctl_addr is compared in full 25 bits against SIZE, so high-address aliasing is impossible.
// - Address SIZE-1 is the last RAM byte. Address SIZE is handled per CONFIGURATION.
// CONFIGURATION
// - Macro UPLOAD_CHECKSUM_EN.
// - Defined:
//   - An 8-bit accumulator sums (mod 256) every byte returned from RAM in the session.
//   - It clears when act rises.
//   - A read of addr==SIZE returns the two's-complement of the sum, so the sum of all SIZE+1 bytes is 8'h00. No RAM access; 1-cycle latency as for the FILL path.
//   - Addresses above SIZE return FILL.
//   - The accumulator updates only on the DONE transition, never on aborted fetches.
// - Undefined: no accumulator; addr==SIZE returns FILL.
// STRUCTURE
// - Shared package ioctl_pkg:
//   - typedef upl_state_t {IDLE,REQ,LAT,DONE}
//   - localparam IOCTL_AW=25
//   - default indexes: IDX_ROM=0, IDX_MOD=1, IDX_NVRAM=4, IDX_DIP=254
// - No sub-module. Latency counter and checksum stay inline (under ~250 lines).
// TESTING
// - Reset: hold reset_n=0 with ioctl_rd toggling -> all outputs 0, no mem_rd.
// - Basic read, RD_LAT=2, RAM[5]=8'h3C, mem_gnt tied 1: rd addr 5 -> wait high 1 cycle after rd, ioctl_din=8'h3C, wait low exactly 4 cycles after rd.
// - Grant stall: mem_gnt held 0 for 10 cycles -> mem_rd and mem_addr stable throughout, wait stays 1, data correct after grant.
// - Out of window (undefined macro), SIZE=256: rd addr 300 and rd addr 256 -> din=8'hFF, wait never asserted, mem_rd never asserted.
// - Abort: ioctl_upload dropped while in REQ -> IDLE next cycle, wait=0.
//   - Then a new session with rd addr 0 -> correct RAM[0].
// - Index filter: rd with ioctl_index=0 -> no response, din unchanged.
// - Checksum (macro defined), SIZE=4, RAM={01,02,03,04}: read 0..4 -> last byte 8'hF6.
//   - An aborted then restarted session yields the same 8'hF6.

Source files
------------

// File: rtl/ioctl_pkg.sv
// Shared ioctl definitions: upload FSM states, address width, index map.
package ioctl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      LAT,
      DONE
   } upl_state_t;

   localparam int IOCTL_AW = 25;

   localparam logic [7:0] IDX_ROM   = 8'd0;
   localparam logic [7:0] IDX_MOD   = 8'd1;
   localparam logic [7:0] IDX_NVRAM = 8'd4;
   localparam logic [7:0] IDX_DIP   = 8'd254;

endpackage

// File: rtl/ioctl_upload_responder.sv
// HPS read-back responder: serves ioctl_rd from a core RAM port.
// Optional trailing checksum byte at addr==SIZE with UPLOAD_CHECKSUM_EN.
module ioctl_upload_responder
   import ioctl_pkg::*;
#(
   parameter logic [7:0] UPLOAD_INDEX = IDX_NVRAM,
   parameter int         SIZE         = 256,
   parameter int         AW           = 16,
   parameter int         RD_LAT       = 1,
   parameter logic [7:0] FILL         = 8'hFF
) (
   input  logic                clk_sys,
   input  logic                reset_n,
   input  logic                ioctl_upload,
   input  logic [7:0]          ioctl_index,
   input  logic                ioctl_rd,
   input  logic [IOCTL_AW-1:0] ioctl_addr,
   output logic [7:0]          ioctl_din,
   output logic                ioctl_wait,
   output logic                mem_rd,
   output logic [AW-1:0]       mem_addr,
   input  logic                mem_gnt,
   input  logic [7:0]          mem_q,
   output logic                busy
);

   localparam logic [IOCTL_AW-1:0] W_SIZE   = IOCTL_AW'(SIZE);
   localparam logic [1:0]          LAT_INIT = 2'(RD_LAT - 1);

   upl_state_t    r_state, w_state_nxt;
   logic [7:0]    r_din, w_din_nxt;
   logic          r_wait, w_wait_nxt;
   logic          r_mem_rd, w_mem_rd_nxt;
   logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
   logic [1:0]    r_cnt, w_cnt_nxt;
   logic          w_act;
   logic          w_in;

`ifdef UPLOAD_CHECKSUM_EN
   logic [7:0]    r_sum, w_sum_nxt;
   logic          r_act_d;
`endif

   assign w_act = ioctl_upload & (ioctl_index == UPLOAD_INDEX);
   assign w_in  = (ioctl_addr < W_SIZE);

   always_comb begin
      w_state_nxt    = r_state;
      w_din_nxt      = r_din;
      w_wait_nxt     = r_wait;
      w_mem_rd_nxt   = r_mem_rd;
      w_mem_addr_nxt = r_mem_addr;
      w_cnt_nxt      = r_cnt;
`ifdef UPLOAD_CHECKSUM_EN
      w_sum_nxt      = r_sum;
`endif
      if (!w_act) begin
         // session abort wins over everything; din keeps its value
         w_state_nxt  = IDLE;
         w_wait_nxt   = 1'b0;
         w_mem_rd_nxt = 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (ioctl_rd) begin
                  if (w_in) begin
                     w_state_nxt    = REQ;
                     w_wait_nxt     = 1'b1;
                     w_mem_rd_nxt   = 1'b1;
                     w_mem_addr_nxt = ioctl_addr[AW-1:0];
`ifdef UPLOAD_CHECKSUM_EN
                  end else if (ioctl_addr == W_SIZE) begin
                     w_din_nxt = ~r_sum + 8'd1;
`endif
                  end else begin
                     w_din_nxt = FILL;
                  end
               end
            end
            REQ: begin
               if (mem_gnt) begin
                  w_mem_rd_nxt = 1'b0;
                  w_cnt_nxt    = LAT_INIT;
                  w_state_nxt  = LAT;
               end
            end
            LAT: begin
               if (r_cnt == 2'd0) begin
                  w_din_nxt   = mem_q;
                  w_state_nxt = DONE;
               end else begin
                  w_cnt_nxt = r_cnt - 2'd1;
               end
            end
            DONE: begin
               w_wait_nxt  = 1'b0;
               w_state_nxt = IDLE;
`ifdef UPLOAD_CHECKSUM_EN
               w_sum_nxt   = r_sum + r_din;
`endif
            end
            default: w_state_nxt = IDLE;
         endcase
`ifdef UPLOAD_CHECKSUM_EN
         if (!r_act_d) w_sum_nxt = 8'h00;
`endif
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_din      <= 8'h00;
         r_wait     <= 1'b0;
         r_mem_rd   <= 1'b0;
         r_mem_addr <= '0;
         r_cnt      <= 2'd0;
`ifdef UPLOAD_CHECKSUM_EN
         r_sum      <= 8'h00;
         r_act_d    <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_din      <= w_din_nxt;
         r_wait     <= w_wait_nxt;
         r_mem_rd   <= w_mem_rd_nxt;
         r_mem_addr <= w_mem_addr_nxt;
         r_cnt      <= w_cnt_nxt;
`ifdef UPLOAD_CHECKSUM_EN
         r_sum      <= w_sum_nxt;
         r_act_d    <= w_act;
`endif
      end
   end

   assign ioctl_din  = r_din;
   assign ioctl_wait = r_wait;
   assign mem_rd     = r_mem_rd;
   assign mem_addr   = r_mem_addr;
   assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_ioctl_upload_responder.sv
// Randomised bench for ioctl_upload_responder with a transaction-timeline model.
// Build with UPLOAD_CHECKSUM_EN to exercise the checksum byte (SIZE=4).
module tb_ioctl_upload_responder;

`ifdef UPLOAD_CHECKSUM_EN
   localparam int SIZE = 4;
   localparam bit CHK  = 1'b1;
`else
   localparam int SIZE = 256;
   localparam bit CHK  = 1'b0;
`endif
   localparam int RD_LAT = 2;
   localparam int AW     = 16;

   logic          clk_sys = 1'b0;
   logic          reset_n;
   logic          ioctl_upload;
   logic [7:0]    ioctl_index;
   logic          ioctl_rd;
   logic [24:0]   ioctl_addr;
   logic [7:0]    ioctl_din;
   logic          ioctl_wait;
   logic          mem_rd;
   logic [AW-1:0] mem_addr;
   logic          mem_gnt;
   logic [7:0]    mem_q;
   logic          busy;

   ioctl_upload_responder #(
      .UPLOAD_INDEX(8'd4),
      .SIZE        (SIZE),
      .AW          (AW),
      .RD_LAT      (RD_LAT),
      .FILL        (8'hFF)
   ) dut (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .ioctl_upload(ioctl_upload),
      .ioctl_index (ioctl_index),
      .ioctl_rd    (ioctl_rd),
      .ioctl_addr  (ioctl_addr),
      .ioctl_din   (ioctl_din),
      .ioctl_wait  (ioctl_wait),
      .mem_rd      (mem_rd),
      .mem_addr    (mem_addr),
      .mem_gnt     (mem_gnt),
      .mem_q       (mem_q),
      .busy        (busy)
   );

   always #5 clk_sys = ~clk_sys;

   // RAM: data appears RD_LAT edges after a granted request, junk otherwise
   logic [7:0] ram [SIZE];
   logic [7:0] dl  [RD_LAT];

   always @(posedge clk_sys) begin
      if (mem_rd && mem_gnt && int'(mem_addr) < SIZE)
         dl[0] <= ram[mem_addr];
      else
         dl[0] <= 8'($urandom);
      for (int i = 1; i < RD_LAT; i++) dl[i] <= dl[i-1];
   end
   assign mem_q = dl[RD_LAT-1];

   int n_chk = 0;
   int n_err = 0;
   int n_wait = 0;
   int n_mrd = 0;

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
      end
   endtask

   // model expectations, valid between edges
   logic          exp_wait  = 1'b0;
   logic          exp_memrd = 1'b0;
   logic [AW-1:0] exp_addr  = '0;
   logic [7:0]    exp_din   = 8'h00;
   logic [7:0]    m_sum     = 8'h00;
   bit            prev_act  = 1'b0;
   bit            cmp_en    = 1'b0;

   always @(negedge clk_sys) begin
      if (cmp_en) begin
         chk("wait", 32'(ioctl_wait), 32'(exp_wait));
         chk("mem_rd", 32'(mem_rd), 32'(exp_memrd));
         chk("busy", 32'(busy), 32'(exp_wait));
         if (exp_memrd) chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
         if (!exp_wait) chk("din", 32'(ioctl_din), 32'(exp_din));
      end
      if (ioctl_wait) n_wait++;
      if (mem_rd) n_mrd++;
   end

   task automatic step();
      bit a;
      a = ioctl_upload && ioctl_index == 8'd4 && reset_n;
      @(posedge clk_sys);
      #1;
      if (a && !prev_act) m_sum = 8'h00;
      prev_act = a;
   endtask

   function automatic logic [7:0] oow_byte(input int unsigned addr);
      if (CHK && addr == SIZE) return 8'(0 - m_sum);
      return 8'hFF;
   endfunction

   task automatic do_read(input int unsigned addr, input int gdly,
                          input bit spam);
      ioctl_rd   = 1'b1;
      ioctl_addr = 25'(addr);
      mem_gnt    = 1'($urandom);
      step();
      ioctl_rd = 1'b0;
      if (addr < SIZE) begin
         exp_wait  = 1'b1;
         exp_memrd = 1'b1;
         exp_addr  = AW'(addr);
         repeat (gdly) begin
            mem_gnt = 1'b0;
            if (spam) begin
               ioctl_rd   = 1'($urandom);
               ioctl_addr = 25'($urandom);
            end
            step();
         end
         ioctl_rd = 1'b0;
         mem_gnt  = 1'b1;
         step();
         exp_memrd = 1'b0;
         repeat (RD_LAT) begin
            mem_gnt = 1'($urandom);
            if (spam) ioctl_rd = 1'($urandom);
            step();
         end
         exp_din  = ram[addr];
         ioctl_rd = 1'b0;
         step();
         exp_wait = 1'b0;
         m_sum    = m_sum + exp_din;
      end else begin
         exp_din = oow_byte(addr);
      end
      ioctl_rd = 1'b0;
      mem_gnt  = 1'($urandom);
      step();
   endtask

   task automatic abort_read(input int unsigned addr, input int k,
                             input bit in_lat);
      ioctl_rd   = 1'b1;
      ioctl_addr = 25'(addr);
      step();
      ioctl_rd  = 1'b0;
      exp_wait  = 1'b1;
      exp_memrd = 1'b1;
      exp_addr  = AW'(addr);
      repeat (k) begin
         mem_gnt = 1'b0;
         step();
      end
      if (in_lat) begin
         mem_gnt = 1'b1;
         step();
         exp_memrd = 1'b0;
      end
      mem_gnt      = 1'b0;
      ioctl_upload = 1'b0;
      step();
      exp_wait  = 1'b0;
      exp_memrd = 1'b0;
      ioctl_upload = 1'b1;
      step();
   endtask

   initial begin
      reset_n      = 1'b0;
      ioctl_upload = 1'b1;
      ioctl_index  = 8'd4;
      ioctl_rd     = 1'b0;
      ioctl_addr   = 25'd5;
      mem_gnt      = 1'b1;
`ifdef UPLOAD_CHECKSUM_EN
      for (int i = 0; i < SIZE; i++) ram[i] = 8'(i + 1);
`else
      for (int i = 0; i < SIZE; i++) ram[i] = 8'($urandom);
      ram[5] = 8'h3C;
`endif
      for (int i = 0; i < RD_LAT; i++) dl[i] = 8'h00;
      cmp_en = 1'b1;

      // reset held with rd toggling
      repeat (4) begin
         ioctl_rd = ~ioctl_rd;
         step();
      end
      chk("rst_din", 32'(ioctl_din), 32'h00);
      chk("rst_wait", 32'(ioctl_wait), 32'h0);
      chk("rst_mem_rd", 32'(mem_rd), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_n_mrd", 32'(n_mrd), 32'h0);
      ioctl_rd = 1'b0;
      reset_n  = 1'b1;
      step();

`ifdef UPLOAD_CHECKSUM_EN
      for (int a = 0; a <= SIZE; a++) do_read(a, a % 3, 1'b0);
      chk("csum_first", 32'(ioctl_din), 32'hF6);
      do_read(SIZE + 1, 0, 1'b0);
      chk("csum_above", 32'(ioctl_din), 32'hFF);
      do_read(1, 0, 1'b0);
      abort_read(2, 1, 1'b1);
      for (int a = 0; a <= SIZE; a++) do_read(a, 0, 1'b0);
      chk("csum_restart", 32'(ioctl_din), 32'hF6);
`else
      n_wait = 0;
      do_read(5, 0, 1'b0);
      chk("basic_din", 32'(ioctl_din), 32'h3C);
      chk("basic_wait_len", 32'(n_wait), 32'd4);

      n_wait = 0;
      do_read(7, 10, 1'b1);
      chk("stall_wait_len", 32'(n_wait), 32'd14);

      n_wait = 0;
      n_mrd  = 0;
      do_read(300, 0, 1'b0);
      chk("oow300_din", 32'(ioctl_din), 32'hFF);
      do_read(5, 0, 1'b0);
      n_wait = 0;
      n_mrd  = 0;
      do_read(256, 0, 1'b0);
      chk("oow256_din", 32'(ioctl_din), 32'hFF);
      chk("oow_no_wait", 32'(n_wait), 32'd0);
      chk("oow_no_mrd", 32'(n_mrd), 32'd0);

      abort_read(9, 3, 1'b0);
      do_read(0, 1, 1'b0);
      abort_read(12, 0, 1'b1);

      ioctl_index = 8'd0;
      n_wait = 0;
      ioctl_rd   = 1'b1;
      ioctl_addr = 25'd5;
      step();
      ioctl_rd = 1'b0;
      step();
      chk("idx_no_wait", 32'(n_wait), 32'd0);
      ioctl_index = 8'd4;
      step();
`endif

      // asynchronous reset in the middle of a fetch
      ioctl_rd   = 1'b1;
      ioctl_addr = 25'd1;
      step();
      ioctl_rd  = 1'b0;
      exp_wait  = 1'b1;
      exp_memrd = 1'b1;
      exp_addr  = AW'(1);
      mem_gnt   = 1'b0;
      step();
      #2;
      reset_n   = 1'b0;
      exp_wait  = 1'b0;
      exp_memrd = 1'b0;
      exp_din   = 8'h00;
      m_sum     = 8'h00;
      #1;
      chk("arst_wait", 32'(ioctl_wait), 32'h0);
      chk("arst_mem_rd", 32'(mem_rd), 32'h0);
      chk("arst_din", 32'(ioctl_din), 32'h00);
      chk("arst_addr", 32'(mem_addr), 32'h0);
      step();
      reset_n = 1'b1;
      step();

      for (int n = 0; n < 300; n++) begin
         int unsigned r, a;
         r = $urandom_range(0, 9);
         if (r < 6)       a = $urandom_range(0, SIZE - 1);
         else if (r == 6) a = SIZE - 1;
         else if (r == 7) a = SIZE;
         else             a = $urandom_range(SIZE + 1, 33554431);
         if (r == 9)
            abort_read($urandom_range(0, SIZE - 1),
                       $urandom_range(0, 3), 1'($urandom));
         else
            do_read(a, $urandom_range(0, 5), 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
